example_mul_share_arb: RTL and testbench

Round-robin arbiter and sequencer that time-shares one signed 14x6 DSP48 multiplier (full-precision 20-bit product) among NUM_REQ requesters. It sits between the per-edge/per-node compute lanes of the GNN kernel and a single multiplier instance. It accepts at most one operand pair per cycle, pipelines it through the multiplier, and returns the product tagged with the originating requester's index.

---
 rtl/example_mul_share_arb.sv | 135 +++++++++++++
 tb/tb_example_mul_share_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/example_mul_share_arb.sv
// Round-robin arbiter that time-shares one signed multiplier among NUM_REQ requesters.
// Products return MUL_STAGES cycles after accept, tagged with the requester index.
module example_mul_share_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned A_WIDTH    = 14,
  parameter int unsigned B_WIDTH    = 6,
  parameter int unsigned P_WIDTH    = 20,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic                         busy,
  output logic [15:0]                  grant_cnt
);

  // Product registers: stage 0 holds operands unless the multiply is registered at accept.
  localparam int unsigned NP  = (MUL_STAGES == 1) ? 1 : MUL_STAGES - 1;
  localparam int unsigned OFF = MUL_STAGES - NP;
  localparam logic [ID_WIDTH:0] NREQ_W = (ID_WIDTH + 1)'(NUM_REQ);

  logic [ID_WIDTH-1:0]   r_ptr;
  logic [15:0]           r_cnt;
  logic [MUL_STAGES-1:0] r_vld;
  logic [ID_WIDTH-1:0]   r_id [MUL_STAGES];
  logic [P_WIDTH-1:0]    r_p  [NP];

  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_gnt_idx;
  logic                  w_gnt_any;
  logic [ID_WIDTH:0]     w_cand;
  logic                  w_accept;
  logic [ID_WIDTH-1:0]   w_ptr_nxt;
  logic [A_WIDTH-1:0]    w_sel_a;
  logic [B_WIDTH-1:0]    w_sel_b;
  logic [P_WIDTH-1:0]    w_p_in;
  logic                  w_p_ld;

  function automatic logic [P_WIDTH-1:0] f_mul(input logic [A_WIDTH-1:0] a,
                                               input logic [B_WIDTH-1:0] b);
    logic signed [P_WIDTH-1:0] ax;
    logic signed [P_WIDTH-1:0] bx;
    ax = {{(P_WIDTH - A_WIDTH){a[A_WIDTH-1]}}, a};
    bx = {{(P_WIDTH - B_WIDTH){b[B_WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  // First valid requester scanning upward from ptr, wrapping at NUM_REQ.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (ID_WIDTH + 1)'(k);
      if (w_cand >= NREQ_W) w_cand = w_cand - NREQ_W;
      if (!w_gnt_any && req_valid[w_cand[ID_WIDTH-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand[ID_WIDTH-1:0];
      end
    end
    if (w_gnt_any && ap_rst_n) w_grant[w_gnt_idx] = 1'b1;
  end

  assign req_ready = w_grant;
  assign w_accept  = w_gnt_any & ap_rst_n;
  assign w_ptr_nxt = (w_gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_WIDTH'(1);
  assign w_sel_a   = req_a[32'(w_gnt_idx) * A_WIDTH +: A_WIDTH];
  assign w_sel_b   = req_b[32'(w_gnt_idx) * B_WIDTH +: B_WIDTH];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_nxt;
      r_cnt <= r_cnt + 16'd1;
    end
  end

  generate
    if (MUL_STAGES == 1) begin : g_direct
      assign w_p_in = f_mul(w_sel_a, w_sel_b);
      assign w_p_ld = w_accept;
    end else begin : g_opreg
      logic [A_WIDTH-1:0] r_a;
      logic [B_WIDTH-1:0] r_b;
      always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_accept) begin
          r_a <= w_sel_a;
          r_b <= w_sel_b;
        end
      end
      assign w_p_in = f_mul(r_a, r_b);
      assign w_p_ld = r_vld[0];
    end
  endgenerate

  // Payload registers only load behind a valid entry, so idle outputs hold their last value.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_vld <= '0;
      for (int s = 0; s < MUL_STAGES; s++) r_id[s] <= '0;
      for (int j = 0; j < NP; j++) r_p[j] <= '0;
    end else begin
      r_vld[0] <= w_accept;
      if (w_accept) r_id[0] <= w_gnt_idx;
      for (int s = 1; s < MUL_STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) r_id[s] <= r_id[s-1];
      end
      if (w_p_ld) r_p[0] <= w_p_in;
      for (int j = 1; j < NP; j++) begin
        if (r_vld[j-1+OFF]) r_p[j] <= r_p[j-1];
      end
    end
  end

  assign rsp_valid = r_vld[MUL_STAGES-1];
  assign rsp_id    = r_id[MUL_STAGES-1];
  assign rsp_p     = r_p[NP-1];
  assign busy      = |r_vld;
  assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_example_mul_share_arb.sv
// Directed bench for example_mul_share_arb: vector table, fairness, reset and wrap sequences.
module tb_example_mul_share_arb;

  localparam int MS = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [55:0] req_a = '0;
  logic [23:0] req_b = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [19:0] rsp_p;
  logic        busy;
  logic [15:0] grant_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int due;
    int id;
    int p;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [3:0]  v;
    logic [55:0] a;
    logic [23:0] b;
    logic [3:0]  rdy;
    int          p;
    int          cnt;
  } vec_t;
  vec_t tbl[15];

  example_mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic logic [55:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {14'(a3), 14'(a2), 14'(a1), 14'(a0)};
  endfunction

  function automatic logic [23:0] pb(input int b0, input int b1, input int b2, input int b3);
    return {6'(b3), 6'(b2), 6'(b1), 6'(b0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, got, got, exp, exp, cyc);
    end
  endtask

  task automatic check_rsp(input string nm);
    logic ev;
    ev = 1'b0;
    if (q.size() > 0) ev = (q[0].due == cyc);
    chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(ev));
    if (ev) begin
      if (rsp_valid === 1'b1) begin
        chk({nm, " rsp_id"}, 32'(rsp_id), 32'(q[0].id));
        chk({nm, " rsp_p"}, {12'd0, rsp_p}, {12'd0, 20'(q[0].p)});
      end
      void'(q.pop_front());
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [55:0] a, input logic [23:0] b,
                      input logic [3:0] er, input int ep, input int ec, input string nm);
    exp_t e;
    @(negedge ap_clk);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
    chk({nm, " req_ready"}, 32'(req_ready), 32'(er));
    chk({nm, " grant_cnt"}, 32'(grant_cnt), 32'(ec));
    check_rsp(nm);
    if (er != 4'b0000) begin
      e.due = cyc + MS;
      e.id  = 0;
      for (int i = 0; i < 4; i++) if (er[i]) e.id = i;
      e.p = ep;
      q.push_back(e);
    end
  endtask

  // One reset edge with all requesters asserting valid, then release.
  task automatic do_reset(input string nm);
    @(negedge ap_clk);
    ap_rst_n  = 1'b0;
    req_valid = 4'hF;
    #1;
    chk({nm, " ready_in_reset"}, 32'(req_ready), 32'd0);
    check_rsp(nm);
    q.delete();
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    req_valid = 4'h0;
    #1;
    chk({nm, " rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    chk({nm, " busy_after"}, 32'(busy), 32'd0);
    chk({nm, " cnt_after"}, 32'(grant_cnt), 32'd0);
    chk({nm, " rsp_id_after"}, 32'(rsp_id), 32'd0);
    chk({nm, " rsp_p_after"}, {12'd0, rsp_p}, 32'd0);
  endtask

  initial begin
    int glitches;
    tbl[0]  = '{4'b0001, pa(8191, 0, 0, 0), pb(31, 0, 0, 0), 4'b0001, 253921, 0};
    tbl[1]  = '{4'b0000, pa(0, 0, 0, 0), pb(0, 0, 0, 0), 4'b0000, 0, 1};
    tbl[2]  = '{4'b0000, pa(0, 0, 0, 0), pb(0, 0, 0, 0), 4'b0000, 0, 1};
    tbl[3]  = '{4'b0100, pa(0, 0, -8192, 0), pb(0, 0, -32, 0), 4'b0100, 262144, 1};
    tbl[4]  = '{4'b0100, pa(0, 0, -8192, 0), pb(0, 0, 31, 0), 4'b0100, -253952, 2};
    tbl[5]  = '{4'b0001, pa(1, 0, 0, 0), pb(1, 0, 0, 0), 4'b0001, 1, 3};
    tbl[6]  = '{4'b1001, pa(-5, 0, 0, 100), pb(7, 0, 0, -3), 4'b1000, -300, 4};
    tbl[7]  = '{4'b1001, pa(-5, 0, 0, 100), pb(7, 0, 0, -3), 4'b0001, -35, 5};
    tbl[8]  = '{4'b1001, pa(-5, 0, 0, 100), pb(7, 0, 0, -3), 4'b1000, -300, 6};
    tbl[9]  = '{4'b0000, pa(0, 0, 0, 0), pb(0, 0, 0, 0), 4'b0000, 0, 7};
    tbl[10] = '{4'b0000, pa(0, 0, 0, 0), pb(0, 0, 0, 0), 4'b0000, 0, 7};
    tbl[11] = '{4'b0010, pa(0, 3, 0, 0), pb(0, 4, 0, 0), 4'b0010, 12, 7};
    tbl[12] = '{4'b0011, pa(-1, 3, 0, 0), pb(-1, 4, 0, 0), 4'b0001, 1, 8};
    tbl[13] = '{4'b0011, pa(-1, 3, 0, 0), pb(-1, 4, 0, 0), 4'b0010, 12, 9};
    tbl[14] = '{4'b0000, pa(0, 0, 0, 0), pb(0, 0, 0, 0), 4'b0000, 0, 10};

    repeat (2) @(posedge ap_clk);
    do_reset("init");

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rdy, tbl[i].p, tbl[i].cnt,
           $sformatf("vec%0d", i));
    end
    step(4'b0000, '0, '0, 4'b0000, 0, 10, "drain");

    // All four requesters held valid: strict rotation from ptr=0.
    do_reset("fair_rst");
    for (int i = 0; i < 8; i++) begin
      step(4'hF, pa(1000, 2000, 3000, 4000), pb(-1, -2, -3, -4), 4'(1 << (i % 4)),
           -1000 * ((i % 4) + 1) * ((i % 4) + 1), i, $sformatf("fair%0d", i));
    end
    step(4'b0000, '0, '0, 4'b0000, 0, 8, "fair_drain0");
    step(4'b0000, '0, '0, 4'b0000, 0, 8, "fair_drain1");

    // Reset while the second accept is still in flight; it must never emerge.
    do_reset("mid_pre");
    step(4'b0001, pa(2, 0, 0, 0), pb(3, 0, 0, 0), 4'b0001, 6, 0, "mid_a");
    step(4'b0010, pa(2, 4, 0, 0), pb(3, 5, 0, 0), 4'b0010, 20, 1, "mid_b");
    chk("mid busy", 32'(busy), 32'd1);
    do_reset("mid_rst");
    step(4'b1010, pa(0, 7, 0, 9), pb(0, 2, 0, 2), 4'b0010, 14, 0, "post_rst");
    step(4'b0000, '0, '0, 4'b0000, 0, 1, "post_drain0");
    step(4'b0000, '0, '0, 4'b0000, 0, 1, "post_drain1");
    step(4'b0000, '0, '0, 4'b0000, 0, 1, "post_drain2");

    // 65536 back-to-back accepts from one requester: counter wraps, responses stay solid.
    do_reset("wrap_rst");
    glitches = 0;
    @(negedge ap_clk);
    req_valid = 4'b0001;
    req_a     = pa(1, 0, 0, 0);
    req_b     = pb(1, 0, 0, 0);
    for (int i = 1; i <= 65536; i++) begin
      @(negedge ap_clk);
      #1;
      if (i >= 2 && rsp_valid !== 1'b1) glitches++;
      if (i == 65535) chk("wrap cnt_max", 32'(grant_cnt), 32'd65535);
    end
    chk("wrap cnt_zero", 32'(grant_cnt), 32'd0);
    chk("wrap rsp_valid_glitches", 32'(glitches), 32'd0);
    req_valid = 4'b0000;
    repeat (3) @(negedge ap_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
